// File: rtl/pe_egress_queue_pkg.sv
// Shared packet layout for the PE egress path and a helper that marks a packet valid.
package pe_egress_queue_pkg;

  typedef struct packed {
    logic        v;
    logic [1:0]  clp;
    logic [3:0]  xp;
    logic [3:0]  yp;
    logic [20:0] data;
  } packet_t;

  localparam int PACKET_W = $bits(packet_t);

  // The head register always presents v=1 regardless of what the PE drove.
  function automatic logic [PACKET_W-1:0] mark_valid(input logic [PACKET_W-1:0] p);
    logic [PACKET_W-1:0] r;
    r = p;
    r[PACKET_W-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pe_egress_queue_mem.sv
// Packet storage array: one synchronous write port, one asynchronous read port, no reset.
module pkt_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_egress_queue.sv
// Per-PE egress FIFO feeding the crossbar peout lane through a registered head.
// Handshake: a packet moves in when ce && in_vld && in_rdy, and out when ce && ack && out_packet.v.
module pe_egress_queue
  import pe_egress_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [PACKET_W-1:0] in_packet,
  input  logic                in_vld,
  output logic                in_rdy,
  output logic [PACKET_W-1:0] out_packet,
  input  logic                ack,
  output logic [PTR_W:0]      count,
  output logic                empty,
  output logic                ovf_err,
  output logic                pe_q_done
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  logic [PTR_W-1:0]    wp, rp, rp_inc;
  logic [PACKET_W-1:0] mem_rdata;
  logic                full, push, pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_rdy    = ce && !full;
  assign push      = ce && in_vld && in_rdy;
  assign pop       = ce && ack && out_packet[PACKET_W-1];
  assign rp_inc    = rp + (PTR_W)'(1);
  assign pe_q_done = empty && !in_vld;

  // Every accepted packet is written; the head register shadows mem[rp].
  pkt_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (PACKET_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wp),
    .wdata (in_packet),
    .raddr (rp_inc),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      out_packet <= '0;
      ovf_err    <= 1'b0;
    end else begin
      if (push) wp <= wp + (PTR_W)'(1);
      if (pop)  rp <= rp_inc;

      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase

      // Next head comes from memory, straight from the PE, or goes empty.
      if (pop) begin
        if (count > ONE_CNT)  out_packet <= mark_valid(mem_rdata);
        else if (push)        out_packet <= mark_valid(in_packet);
        else                  out_packet <= '0;
      end else if (push && empty) begin
        out_packet <= mark_valid(in_packet);
      end

      if (ce && in_vld && full) ovf_err <= 1'b1;
    end
  end

endmodule
